// File: rtl/pc_ctrl.sv
// pc_ctrl: pipeline stall/flush sequencing and PC redirect arbitration with a held-branch buffer and stall-cycle counter
module pc_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_addr_i,
  input  logic             excp_flag_i,
  input  logic [31:0]      excp_addr_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             pc_branch_flag_o,
  output logic [31:0]      pc_branch_addr_o,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;
  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);
  state_t state, state_nx;
  logic pending, pending_nx;
  logic [31:0] pend_addr, pend_addr_nx;
  logic [3:0] fcnt, fcnt_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [5:0] base;
  logic hold;
  assign base = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 : stallreq_id ? 6'b000111 : 6'b000000;
  assign hold = base[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pending <= 1'b0;
      pend_addr <= '0;
      fcnt <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      pending <= pending_nx;
      pend_addr <= pend_addr_nx;
      fcnt <= fcnt_nx;
      cnt_q <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    pending_nx = pending;
    pend_addr_nx = pend_addr;
    fcnt_nx = fcnt;
    cnt_nx = cnt_q;
    if (excp_flag_i) begin
      state_nx = FLUSH;
      fcnt_nx = FC;
      pending_nx = 1'b0;
    end else if (state == FLUSH) begin
      fcnt_nx = fcnt - 4'd1;
      state_nx = fcnt <= 4'd1 ? RUN : FLUSH;
    end else if (hold) begin
      state_nx = HOLD;
      cnt_nx = &cnt_q ? cnt_q : cnt_q + 1'b1;
      pending_nx = pending | branch_flag_i;
      pend_addr_nx = branch_flag_i ? branch_target_addr_i : pend_addr;
    end else begin
      state_nx = RUN;
      pending_nx = 1'b0;
    end
  end
  always_comb begin
    stall = '0;
    flush = 1'b0;
    pc_branch_flag_o = 1'b0;
    pc_branch_addr_o = '0;
    redirect_pending = 1'b0;
    stall_cnt = '0;
    if (!rst) begin
      redirect_pending = pending;
      stall_cnt = cnt_q;
      if (excp_flag_i) begin
        flush = 1'b1;
        pc_branch_flag_o = 1'b1;
        pc_branch_addr_o = excp_addr_i;
      end else if (state == FLUSH) begin
        flush = 1'b1;
        stall = 6'b000001;
      end else begin
        stall = base;
        pc_branch_flag_o = !hold && (branch_flag_i || pending);
        pc_branch_addr_o = hold ? '0 : branch_flag_i ? branch_target_addr_i : pending ? pend_addr : '0;
      end
    end
  end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: randomized and directed checks of pc_ctrl against a behavioural model
module tb_pc_ctrl;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst, sid, sex, smem, br, xf;
  logic [31:0] ba, xa;
  logic [5:0] stall;
  logic flush, pc_branch_flag_o, redirect_pending;
  logic [31:0] pc_branch_addr_o;
  logic [CW-1:0] stall_cnt;
  logic [31:0] tb_pc;
  int n_cmp = 0;
  int n_err = 0;
  int m_fl;
  bit m_pend;
  logic [31:0] m_pa;
  int m_cnt;
  logic [5:0] e_stall;
  logic e_flush, e_jf, e_rp;
  logic [31:0] e_addr;
  logic [40+CW:0] obs, expv;
  pc_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .branch_flag_i(br), .branch_target_addr_i(ba), .excp_flag_i(xf), .excp_addr_i(xa),
    .stall(stall), .flush(flush), .pc_branch_flag_o(pc_branch_flag_o),
    .pc_branch_addr_o(pc_branch_addr_o), .redirect_pending(redirect_pending), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    tb_pc <= rst ? 32'd0 : stall[0] ? tb_pc : pc_branch_flag_o ? pc_branch_addr_o : tb_pc + 32'd1;
  assign obs = {stall, flush, pc_branch_flag_o, pc_branch_flag_o ? pc_branch_addr_o : 32'd0, redirect_pending, stall_cnt};
  task automatic apply(input logic r, i, e, m, b, input logic [31:0] a, input logic x, input logic [31:0] xadr);
    logic h;
    rst = r; sid = i; sex = e; smem = m; br = b; ba = a; xf = x; xa = xadr;
    #1;
    h = i | e | m;
    e_stall = 0; e_flush = 0; e_jf = 0; e_addr = 0; e_rp = 0;
    if (!r) begin
      e_rp = m_pend;
      if (x) begin
        e_flush = 1; e_jf = 1; e_addr = xadr;
      end else if (m_fl > 0) begin
        e_flush = 1; e_stall = 6'b000001;
      end else begin
        e_stall = m ? 6'b011111 : e ? 6'b001111 : i ? 6'b000111 : 6'b000000;
        if (!h && b) begin e_jf = 1; e_addr = a; end
        else if (!h && m_pend) begin e_jf = 1; e_addr = m_pa; end
      end
    end
    expv = {e_stall, e_flush, e_jf, e_addr, e_rp, r ? CW'(0) : CW'(m_cnt)};
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_fl = 0; m_pend = 0; m_pa = 0; m_cnt = 0;
    end else if (xf) begin
      m_fl = FC; m_pend = 0;
    end else if (m_fl > 0) begin
      m_fl--;
    end else if (sid | sex | smem) begin
      if (m_cnt < CMAX) m_cnt++;
      if (br) begin m_pend = 1; m_pa = ba; end
    end else begin
      m_pend = 0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 1, 1, 1, 32'h55, 1, 32'h66);
      n_cmp++;
      if (obs !== '0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", obs); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL idle_outputs got=%h exp=%h", obs, expv); end
      n_cmp++;
      if (tb_pc !== 32'(k)) begin n_err++; $display("FAIL idle_pc got=%h exp=%h", tb_pc, k); end
      tick();
    end
  endtask
  task automatic test_branch();
    apply(0, 0, 0, 0, 1, 32'h40, 0, 0);
    n_cmp++;
    if (obs !== expv || pc_branch_flag_o !== 1'b1 || pc_branch_addr_o !== 32'h40) begin
      n_err++; $display("FAIL live_branch got=%h exp=%h", obs, expv);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (tb_pc !== 32'h40) begin n_err++; $display("FAIL branch_pc got=%h exp=00000040", tb_pc); end
    tick();
  endtask
  task automatic test_stall_pending();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 1, 0, k == 0, k == 0 ? 32'h80 : 32'h0, 0, 0);
      n_cmp++;
      if (obs !== expv || stall !== 6'b001111 || pc_branch_flag_o !== 1'b0 || (k > 0 && redirect_pending !== 1'b1)) begin
        n_err++; $display("FAIL hold_pending cyc=%0d got=%h exp=%h", k, obs, expv);
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== expv || pc_branch_flag_o !== 1'b1 || pc_branch_addr_o !== 32'h80 || stall_cnt !== 4'd4) begin
      n_err++; $display("FAIL pending_release got=%h exp=%h", obs, expv);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== expv || pc_branch_flag_o !== 1'b0) begin n_err++; $display("FAIL release_once got=%h exp=%h", obs, expv); end
    tick();
  endtask
  task automatic test_live_overrides();
    do_reset();
    apply(0, 1, 0, 0, 1, 32'h80, 0, 0);
    tick();
    apply(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 1, 32'hC0, 0, 0);
    n_cmp++;
    if (obs !== expv || pc_branch_addr_o !== 32'hC0 || pc_branch_flag_o !== 1'b1) begin
      n_err++; $display("FAIL live_over_pending got=%h exp=%h", obs, expv);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs !== expv || pc_branch_flag_o !== 1'b0 || redirect_pending !== 1'b0) begin
        n_err++; $display("FAIL stale_pending cyc=%0d got=%h exp=%h", k, obs, expv);
      end
      tick();
    end
  endtask
  task automatic test_exception();
    do_reset();
    apply(0, 0, 0, 1, 1, 32'h200, 0, 0);
    tick();
    apply(0, 0, 0, 1, 1, 32'h300, 1, 32'h100);
    n_cmp++;
    if (obs !== expv || pc_branch_flag_o !== 1'b1 || pc_branch_addr_o !== 32'h100 || flush !== 1'b1 || stall !== 6'b0) begin
      n_err++; $display("FAIL excp_redirect got=%h exp=%h", obs, expv);
    end
    tick();
    for (int k = 0; k < FC; k++) begin
      apply(0, 1'($urandom), 1'($urandom), 1'($urandom), 1, $urandom, 0, 0);
      n_cmp++;
      if (obs !== expv || flush !== 1'b1 || stall !== 6'b000001 || pc_branch_flag_o !== 1'b0 || tb_pc !== 32'h100) begin
        n_err++; $display("FAIL flush_cycle cyc=%0d got=%h exp=%h pc=%h", k, obs, expv, tb_pc);
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== expv || flush !== 1'b0 || stall_cnt !== 4'd1 || tb_pc !== 32'h100) begin
      n_err++; $display("FAIL after_flush got=%h exp=%h pc=%h", obs, expv, tb_pc);
    end
    tick();
  endtask
  task automatic test_saturate_reset();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply(0, 0, 1, 0, k == 5, 32'hABC, 0, 0);
      n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL sat_hold cyc=%0d got=%h exp=%h", k, obs, expv); end
      tick();
    end
    apply(0, 0, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (stall_cnt !== 4'hF || redirect_pending !== 1'b1) begin
      n_err++; $display("FAIL saturate got=%h/%b exp=f/1", stall_cnt, redirect_pending);
    end
    apply(1, 0, 1, 0, 1, 32'hDEF, 0, 0);
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL rst_midhold got=%h exp=0", obs); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== '0 || obs !== expv) begin n_err++; $display("FAIL pending_lost got=%h exp=0", obs); end
    tick();
  endtask
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      apply($urandom_range(60) == 0, $urandom_range(5) == 0, $urandom_range(6) == 0, $urandom_range(8) == 0,
            $urandom_range(3) == 0, $urandom, $urandom_range(20) == 0, $urandom);
      n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", k, obs, expv); end
      tick();
    end
  endtask
  initial begin
    m_fl = 0; m_pend = 0; m_pa = 0; m_cnt = 0;
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_branch();
    test_stall_pending();
    test_live_overrides();
    test_exception();
    test_saturate_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
